// File: rtl/axis_image_sink_pkg.sv
// Shared definitions for the AXI-Stream image sink: FSM state encoding,
// pixel width written to frame memory, and the line-length helper.
package cnn_axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_RECV     = 2'd2,
    ST_DONE     = 2'd3
  } sink_state_t;

  // Only the low byte of each beat is stored in frame memory.
  localparam int PIXEL_WIDTH = 8;

  // One beat carries one byte, so a line is cols * channels beats long.
  function automatic int line_beats(input int cols, input int channels);
    return cols * channels;
  endfunction

endpackage

// File: rtl/axis_image_sink_if.sv
// AXI-Stream video-style channel: tuser marks start of frame, tlast end of line.
interface axis_image_sink_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);

endinterface

// File: rtl/axis_image_sink.sv
// Captures one image frame from an AXI-Stream source into a byte-wide frame
// memory write port. Frames are armed by enable, aligned on tuser, and line
// boundaries are enforced by a column counter with sticky error reporting
// whenever tlast disagrees with the expected line length.
module axis_image_sink
  import cnn_axis_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int IMG_COLS             = 28,
  parameter int IMG_ROWS             = 28,
  parameter int IMG_CHANNELS         = 1,
  parameter int ADDR_WIDTH           = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  axis_image_sink_if.slave       s_axis,
  input  logic                   enable,
  input  logic                   err_clear,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] wr_data,
  output logic                   frame_done,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic [15:0]            drop_count,
  output logic                   err_sof,
  output logic                   err_eol
);

  localparam int LINE_BEATS = line_beats(IMG_COLS, IMG_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] LB_A     = ADDR_WIDTH'(LINE_BEATS);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(IMG_ROWS - 1);

  sink_state_t           state_reg;
  logic [ADDR_WIDTH-1:0] row_reg;
  logic [ADDR_WIDTH-1:0] col_reg;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata_w;
  logic                            unused_tdata_hi;

  logic                  accept;
  logic                  take_pixel;
  logic                  drop_beat;
  logic                  last_col;
  logic                  line_close;
  logic                  eol_bad;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] eff_row;
  logic [ADDR_WIDTH-1:0] eff_col;
  logic [ADDR_WIDTH-1:0] pix_addr;

  // Upper data bits carry nothing we store; fold them away explicitly.
  assign tdata_w = s_axis.tdata;
  generate
    if (C_S_AXIS_TDATA_WIDTH > PIXEL_WIDTH) begin : g_hi_bits
      assign unused_tdata_hi = ^tdata_w[C_S_AXIS_TDATA_WIDTH-1:PIXEL_WIDTH];
    end else begin : g_no_hi_bits
      assign unused_tdata_hi = 1'b0;
    end
  endgenerate

  // Ready is a pure decode of the state register so it never depends on tvalid.
  assign s_axis.tready = (state_reg == ST_WAIT_SOF) || (state_reg == ST_RECV);
  assign busy          = (state_reg == ST_RECV) || (state_reg == ST_DONE);

  assign accept     = s_axis.tvalid && s_axis.tready;
  assign take_pixel = accept && ((state_reg == ST_RECV) ||
                                 ((state_reg == ST_WAIT_SOF) && s_axis.tuser));
  assign drop_beat  = accept && (state_reg == ST_WAIT_SOF) && !s_axis.tuser;

  // A start-of-frame beat always lands at pixel 0, whether it opens the frame
  // or restarts one already in progress.
  assign eff_row    = s_axis.tuser ? '0 : row_reg;
  assign eff_col    = s_axis.tuser ? '0 : col_reg;
  assign pix_addr   = eff_row * LB_A + eff_col;
  assign last_col   = (eff_col == LAST_COL);
  assign line_close = last_col || s_axis.tlast;
  assign eol_bad    = (last_col != s_axis.tlast);
  assign last_row   = (eff_row == LAST_ROW);

  // Frame-memory write port: one registered write per accepted pixel beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= take_pixel;
      if (take_pixel) begin
        wr_addr <= pix_addr;
        wr_data <= tdata_w[PIXEL_WIDTH-1:0];
      end
    end
  end

  // Frame FSM with row/column tracking, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      row_reg     <= '0;
      col_reg     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      err_sof     <= 1'b0;
      err_eol     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Clear first so that a new error in the same cycle overrides it.
      if (err_clear) begin
        err_sof <= 1'b0;
        err_eol <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg <= ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF, ST_RECV: begin
          if (drop_beat && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
          end
          if (take_pixel) begin
            if ((state_reg == ST_RECV) && s_axis.tuser) begin
              err_sof <= 1'b1;
            end
            if (eol_bad) begin
              err_eol <= 1'b1;
            end
            if (line_close) begin
              col_reg <= '0;
              if (last_row) begin
                row_reg     <= '0;
                state_reg   <= ST_DONE;
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
              end else begin
                row_reg   <= eff_row + 1'b1;
                state_reg <= ST_RECV;
              end
            end else begin
              col_reg   <= eff_col + 1'b1;
              row_reg   <= eff_row;
              state_reg <= ST_RECV;
            end
          end
        end
        ST_DONE: begin
          state_reg <= enable ? ST_WAIT_SOF : ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_image_sink.sv
// Randomized and directed stimulus for the image sink, checked against a
// frame-level reference model of where each accepted beat must be stored.
module tb_axis_image_sink;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int CH   = 1;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LB   = COLS * CH;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          err_clear;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_done;
  logic          busy;
  logic [15:0]   frame_count;
  logic [15:0]   drop_count;
  logic          err_sof;
  logic          err_eol;

  axis_image_sink_if #(.DATA_WIDTH(DW)) s_axis ();

  axis_image_sink #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .IMG_COLS(COLS),
    .IMG_ROWS(ROWS),
    .IMG_CHANNELS(CH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_axis(s_axis),
    .enable(enable),
    .err_clear(err_clear),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .busy(busy),
    .frame_count(frame_count),
    .drop_count(drop_count),
    .err_sof(err_sof),
    .err_eol(err_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    bit          user;
    bit          last;
  } beat_t;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t beats[$];
  int    obs_w[$];
  int    exp_w[$];
  int    done_seen;
  int    exp_drop, exp_sof, exp_eol, exp_done;

  // Observe the memory write port and frame_done pulses mid-cycle.
  always @(negedge clk) begin
    if (wr_en) obs_w.push_back((int'(wr_addr) << 8) | int'(wr_data));
    if (frame_done) done_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic add_beat(input logic [31:0] d, input bit u, input bit l);
    beat_t b;
    b.data = d; b.user = u; b.last = l;
    beats.push_back(b);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    s_axis.tvalid = 1'b0;
    err_clear = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    obs_w.delete();
    done_seen = 0;
  endtask

  // Present one beat, optionally after random idle cycles, and return #1 after
  // the edge that accepted it. Ready depends only on state, so a ready seen
  // after the previous edge means the next edge accepts.
  task automatic push_beat(input beat_t b, input bit gaps, input bit clr);
    int  n;
    bit  acc;
    if (gaps) begin
      s_axis.tvalid = 1'b0;
      n = 0;
      while ($urandom_range(0, 1) == 1 && n < 8) begin
        @(posedge clk); #1;
        n++;
      end
    end
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = b.data;
    s_axis.tuser  = b.user;
    s_axis.tlast  = b.last;
    err_clear     = clr;
    n = 0;
    forever begin
      acc = s_axis.tready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        check_val("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_axis.tvalid = 1'b0;
    err_clear     = 1'b0;
  endtask

  task automatic send_all(input bit gaps);
    foreach (beats[i]) push_beat(beats[i], gaps, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  // Frame-level reference: walk the accepted beats, tracking only whether a
  // frame is open and the pixel position inside it.
  task automatic run_model();
    bit in_frame;
    int line, pos;
    bit full;
    exp_w.delete();
    exp_drop = 0; exp_sof = 0; exp_eol = 0; exp_done = 0;
    in_frame = 0; line = 0; pos = 0;
    foreach (beats[i]) begin
      if (!in_frame) begin
        if (!beats[i].user) begin
          if (exp_drop < 16'hFFFF) exp_drop++;
          continue;
        end
        in_frame = 1; line = 0; pos = 0;
      end else if (beats[i].user) begin
        exp_sof = 1; line = 0; pos = 0;
      end
      exp_w.push_back(((line * LB + pos) << 8) | int'(beats[i].data[7:0]));
      full = (pos == LB - 1);
      if (full != beats[i].last) exp_eol = 1;
      if (full || beats[i].last) begin
        pos = 0;
        line++;
        if (line == ROWS) begin
          exp_done++;
          in_frame = 0;
        end
      end else begin
        pos++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    run_model();
    check_val($sformatf("%s.nwrites", tag), obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      check_val($sformatf("%s.write%0d", tag, i), obs_w[i], exp_w[i]);
    check_val($sformatf("%s.drop_count", tag), drop_count, exp_drop);
    check_val($sformatf("%s.err_sof", tag), err_sof, exp_sof);
    check_val($sformatf("%s.err_eol", tag), err_eol, exp_eol);
    check_val($sformatf("%s.frame_count", tag), frame_count, exp_done & 16'hFFFF);
    check_val($sformatf("%s.frame_done_pulses", tag), done_seen, exp_done);
  endtask

  task automatic clean_frame(input int base);
    for (int i = 0; i < 8; i++)
      add_beat(32'hABCD_0000 | (base + i), (i == 0), (i % LB == LB - 1));
  endtask

  initial begin
    enable = 1'b0; err_clear = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tuser = 1'b0; s_axis.tlast = 1'b0;
    reset_dut();

    // Reset state
    check_val("rst.tready", s_axis.tready, 1'b0);
    check_val("rst.busy", busy, 1'b0);
    check_val("rst.wr_en", wr_en, 1'b0);
    check_val("rst.wr_addr", wr_addr, 0);
    check_val("rst.frame_count", frame_count, 0);
    check_val("rst.drop_count", drop_count, 0);
    check_val("rst.errs", {err_sof, err_eol}, 2'b00);

    // Clean frame with latency and end-of-frame handshake checks
    enable = 1'b1;
    beats.delete();
    clean_frame(32'h10);
    foreach (beats[i]) begin
      push_beat(beats[i], 1'b0, 1'b0);
      if (i == 0) begin
        check_val("clean.first_wr_en", wr_en, 1'b1);
        check_val("clean.first_wr_addr", wr_addr, 0);
        check_val("clean.first_wr_data", wr_data, 8'h10);
        check_val("clean.busy_recv", busy, 1'b1);
      end
    end
    check_val("clean.tready_after_last", s_axis.tready, 1'b0);
    check_val("clean.frame_done_pulse", frame_done, 1'b1);
    check_val("clean.busy_done", busy, 1'b1);
    @(posedge clk); #1;
    check_val("clean.frame_done_cleared", frame_done, 1'b0);
    check_val("clean.busy_after", busy, 1'b0);
    check_val("clean.tready_wait_sof", s_axis.tready, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    compare_all("clean");

    // Garbage before start of frame
    reset_dut(); enable = 1'b1;
    beats.delete();
    for (int i = 0; i < 3; i++) add_beat(32'h0000_00E0 + i, 1'b0, (i == 1));
    clean_frame(32'h10);
    send_all(1'b0);
    compare_all("presof");

    // Early tlast on beat 2 of row 0
    reset_dut(); enable = 1'b1;
    beats.delete();
    for (int i = 0; i < 7; i++) add_beat(32'h30 + i, (i == 0), (i == 2 || i == 6));
    send_all(1'b0);
    compare_all("early_eol");

    // tuser reasserted on beat 5
    reset_dut(); enable = 1'b1;
    beats.delete();
    for (int i = 0; i < 13; i++)
      add_beat(32'h50 + i, (i == 0 || i == 5), (i == 3 || i == 8 || i == 12));
    send_all(1'b0);
    compare_all("resof");

    // Clean frame with random valid gaps
    reset_dut(); enable = 1'b1;
    beats.delete();
    clean_frame(32'h10);
    send_all(1'b1);
    compare_all("gaps");

    // Reset after beat 4 discards the partial frame
    reset_dut(); enable = 1'b1;
    beats.delete();
    clean_frame(32'h70);
    for (int i = 0; i < 5; i++) push_beat(beats[i], 1'b1, 1'b0);
    enable = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_val("midrst.nwrites", obs_w.size(), 5);
    check_val("midrst.frame_done_pulses", done_seen, 0);
    check_val("midrst.tready", s_axis.tready, 1'b0);
    check_val("midrst.busy", busy, 1'b0);
    check_val("midrst.frame_count", frame_count, 0);
    check_val("midrst.drop_count", drop_count, 0);

    // err_clear in the same cycle as an early tlast, then clear alone
    reset_dut(); enable = 1'b1;
    beats.delete();
    for (int i = 0; i < 7; i++) add_beat(32'h90 + i, (i == 0), (i == 2 || i == 6));
    foreach (beats[i]) push_beat(beats[i], 1'b0, (i == 2));
    check_val("clr_race.err_eol", err_eol, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check_val("clr_alone.err_eol", err_eol, 1'b0);
    check_val("clr_alone.err_sof", err_sof, 1'b0);

    // Dropping enable mid-frame still completes the frame, then idles
    reset_dut(); enable = 1'b1;
    beats.delete();
    clean_frame(32'hC0);
    foreach (beats[i]) begin
      push_beat(beats[i], 1'b0, 1'b0);
      if (i == 2) enable = 1'b0;
    end
    repeat (4) begin @(posedge clk); #1; end
    compare_all("enable_drop");
    check_val("enable_drop.tready_idle", s_axis.tready, 1'b0);

    // Randomized frames with random errors and gaps
    for (int it = 0; it < 6; it++) begin
      int ng;
      reset_dut(); enable = 1'b1;
      beats.delete();
      ng = $urandom_range(0, 3);
      for (int i = 0; i < ng; i++) add_beat($urandom, 1'b0, $urandom_range(0, 1));
      for (int i = 0; i < 12; i++) begin
        bit u, l;
        u = (i == 0) || ($urandom_range(0, 11) == 0);
        l = (i % LB == LB - 1);
        if ($urandom_range(0, 9) == 0) l = !l;
        add_beat($urandom, u, l);
      end
      send_all(1'b1);
      compare_all($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
